// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its executor.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic        [4:0]  address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [63:0] result_t;

    typedef enum logic [2:0] {
        IDLE, FETCH, EXEC, OUT, DONE
    } exec_state_t;

    // Remaining-instruction counter holds 0..32.
    localparam int CNT_W = 6;

endpackage

// File: rtl/instr_alu.sv
// Combinational opcode evaluator; operands widened to 64 bits before use.
module instr_alu
    import instr_register_pkg::*;
(
    input  opcode_t  opcode_i,
    input  operand_t op_a_i,
    input  operand_t op_b_i,
    output result_t  result_o,
    output logic     div0_o
);

    result_t a;
    result_t b;

    assign a = {{32{op_a_i[31]}}, op_a_i};
    assign b = {{32{op_b_i[31]}}, op_b_i};

    // Opcode decode; divide/modulo by zero yields 0 with the error flag.
    always_comb begin
        result_o = '0;
        div0_o   = 1'b0;
        unique case (opcode_i)
            ZERO:  result_o = '0;
            PASSA: result_o = a;
            PASSB: result_o = b;
            ADD:   result_o = a + b;
            SUB:   result_o = a - b;
            MULT:  result_o = a * b;
            DIV: begin
                if (op_b_i == '0) div0_o   = 1'b1;
                else              result_o = a / b;
            end
            MOD: begin
                if (op_b_i == '0) div0_o   = 1'b1;
                else              result_o = a % b;
            end
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_executor.sv
// Walks read_pointer over a block of instruction locations and emits one
// ALU result per instruction on a valid/ready port.
module instr_executor
    import instr_register_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  address_t           first_addr,
    input  logic [CNT_W-1:0]   count,
    output address_t           read_pointer,
    input  instruction_t       instruction_word,
    output logic               res_valid,
    input  logic               res_ready,
    output result_t            res_data,
    output address_t           res_addr,
    output opcode_t            res_opc,
    output logic               res_err,
    output logic               busy,
    output logic               done
);

    exec_state_t        state_q;
    address_t           rptr_q;
    logic [CNT_W-1:0]   remain_q;
    instruction_t       instr_q;
    logic               res_valid_q;
    result_t            res_data_q;
    address_t           res_addr_q;
    opcode_t            res_opc_q;
    logic               res_err_q;
    logic               busy_q;
    logic               done_q;

    result_t            alu_res;
    logic               alu_div0;

    instr_alu u_alu (
        .opcode_i (instr_q.opc),
        .op_a_i   (instr_q.op_a),
        .op_b_i   (instr_q.op_b),
        .result_o (alu_res),
        .div0_o   (alu_div0)
    );

    // Run sequencer: address/remaining counters and registered result port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rptr_q      <= '0;
            remain_q    <= '0;
            instr_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_addr_q  <= '0;
            res_opc_q   <= ZERO;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rptr_q   <= first_addr;
                        remain_q <= count;
                        busy_q   <= 1'b1;
                        if (count != '0) begin
                            state_q <= FETCH;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    instr_q <= instruction_word;
                    state_q <= EXEC;
                end
                EXEC: begin
                    // Pointer is unchanged since FETCH, so it names this result.
                    res_data_q  <= alu_res;
                    res_addr_q  <= rptr_q;
                    res_opc_q   <= instr_q.opc;
                    res_err_q   <= alu_div0;
                    res_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        remain_q    <= remain_q - 1'b1;
                        if (remain_q == CNT_W'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            rptr_q  <= rptr_q + 1'b1;
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign read_pointer = rptr_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_addr     = res_addr_q;
    assign res_opc      = res_opc_q;
    assign res_err      = res_err_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_instr_executor.sv
// Directed bench for instr_executor with an arithmetic reference model.
module tb_instr_executor;
    import instr_register_pkg::*;

    logic         clk;
    logic         reset;
    logic         start;
    address_t     first_addr;
    logic [5:0]   count;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         res_valid;
    logic         res_ready;
    result_t      res_data;
    address_t     res_addr;
    opcode_t      res_opc;
    logic         res_err;
    logic         busy;
    logic         done;

    instruction_t mem [32];
    assign instruction_word = mem[read_pointer];

    instr_executor dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .first_addr       (first_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_addr         (res_addr),
        .res_opc          (res_opc),
        .res_err          (res_err),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint   data;
        address_t addr;
        opcode_t  opc;
        bit       err;
    } exp_t;

    exp_t   exp_q [$];
    longint got_q [$];
    bit     goterr_q [$];
    int     nvec = 0;
    int     nerr = 0;

    task automatic chk(input string name, input longint got, input longint expv);
        nvec++;
        if (got !== expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Reference arithmetic written from the opcode definitions.
    function automatic longint model(input opcode_t o, input int a, input int b, output bit err);
        longint la, lb, q, r;
        la  = a;
        lb  = b;
        err = 1'b0;
        case (o)
            PASSA: return la;
            PASSB: return lb;
            ADD:   return la + lb;
            SUB:   return la - lb;
            MULT:  return la * lb;
            DIV, MOD: begin
                if (b == 0) begin
                    err = 1'b1;
                    return 0;
                end
                q = (la < 0 ? -la : la) / (lb < 0 ? -lb : lb);
                r = (la < 0 ? -la : la) - q * (lb < 0 ? -lb : lb);
                if (o == DIV) return ((la < 0) != (lb < 0)) ? -q : q;
                return (la < 0) ? -r : r;
            end
            default: return 0;
        endcase
    endfunction

    // Result port check against the head of the expected queue.
    always @(negedge clk) begin : cmp
        exp_t e;
        if (!reset && res_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = exp_q[0];
                chk("res_data", res_data, e.data);
                chk("res_addr", longint'(res_addr), longint'(e.addr));
                chk("res_opc", longint'(res_opc), longint'(e.opc));
                chk("res_err", longint'(res_err), longint'(e.err));
                chk("rptr_hold", longint'(read_pointer), longint'(e.addr));
                if (res_ready) begin
                    got_q.push_back(res_data);
                    goterr_q.push_back(res_err);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic lit(input string name, input int idx, input longint expv, input bit experr);
        if (idx < got_q.size()) begin
            chk(name, got_q[idx], expv);
            chk({name, "_err"}, longint'(goterr_q[idx]), longint'(experr));
        end else begin
            chk({name, "_missing"}, got_q.size(), idx + 1);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, longint'(res_valid), 0);
        chk({tag, "_data"},  res_data, 0);
        chk({tag, "_addr"},  longint'(res_addr), 0);
        chk({tag, "_opc"},   longint'(res_opc), longint'(ZERO));
        chk({tag, "_err"},   longint'(res_err), 0);
        chk({tag, "_busy"},  longint'(busy), 0);
        chk({tag, "_done"},  longint'(done), 0);
        chk({tag, "_rptr"},  longint'(read_pointer), 0);
    endtask

    // One run: build expectations, pulse start, drive ready, time the run.
    task automatic run(input address_t fa, input logic [5:0] cnt, input int stall, input int extra_at);
        int       first_valid = -1;
        int       done_c = -1;
        int       stall_left = stall;
        address_t ad;
        bit       e;
        exp_t     x;
        got_q.delete();
        goterr_q.delete();
        for (int i = 0; i < int'(cnt); i++) begin
            ad     = fa + 5'(i);
            x.data = model(mem[ad].opc, mem[ad].op_a, mem[ad].op_b, e);
            x.addr = ad;
            x.opc  = mem[ad].opc;
            x.err  = e;
            exp_q.push_back(x);
        end
        @(posedge clk); #1;
        start = 1'b1; first_addr = fa; count = cnt;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            start = (c == extra_at);
            if (c == extra_at) begin
                first_addr = 5'd0;
                count      = 6'd5;
            end
            if (c == 0) chk("busy_after_start", longint'(busy), 1);
            if (done) begin
                done_c = c;
                break;
            end
            if (res_valid && first_valid < 0) first_valid = c;
            if (res_valid && stall_left > 0) begin
                res_ready = 1'b0;
                stall_left--;
            end else begin
                res_ready = 1'b1;
            end
        end
        start = 1'b0;
        res_ready = 1'b1;
        if (done_c < 0) chk("done_timeout", 0, 1);
        chk("done_cycle", done_c, (cnt == 0) ? 0 : 3 * int'(cnt) + stall);
        if (cnt != 0) chk("first_valid_cycle", first_valid, 2);
        chk("busy_in_done", longint'(busy), 1);
        chk("results_left", exp_q.size(), 0);
        @(posedge clk); #1;
        chk("done_one_cycle", longint'(done), 0);
        chk("idle_busy", longint'(busy), 0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; first_addr = '0; count = '0; res_ready = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = '{opc: ZERO, op_a: 0, op_b: 0};
        #2;
        chk_reset_vals("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Single ADD
        mem[3] = '{opc: ADD, op_a: 7, op_b: -2};
        run(5'd3, 6'd1, 0, -1);
        lit("add_7_m2", 0, 5, 0);

        // Wrap 30, 31, 0
        mem[30] = '{opc: SUB,   op_a: 10, op_b: 4};
        mem[31] = '{opc: MULT,  op_a: -3, op_b: 5};
        mem[0]  = '{opc: PASSB, op_a: 0,  op_b: 9};
        run(5'd30, 6'd3, 0, -1);
        lit("sub_10_4", 0, 6, 0);
        lit("mult_m3_5", 1, -15, 0);
        lit("passb_9", 2, 9, 0);

        // Division semantics
        mem[10] = '{opc: DIV,   op_a: -7, op_b: 2};
        mem[11] = '{opc: MOD,   op_a: -7, op_b: 2};
        mem[12] = '{opc: DIV,   op_a: 5,  op_b: 0};
        mem[13] = '{opc: MOD,   op_a: 5,  op_b: 0};
        mem[14] = '{opc: PASSA, op_a: -42, op_b: 0};
        mem[15] = '{opc: MULT,  op_a: 32'sh7fffffff, op_b: 32'sh7fffffff};
        run(5'd10, 6'd6, 0, -1);
        lit("div_m7_2", 0, -3, 0);
        lit("mod_m7_2", 1, -1, 0);
        lit("div_5_0", 2, 0, 1);
        lit("mod_5_0", 3, 0, 1);
        lit("passa_m42", 4, -42, 0);
        lit("mult_max", 5, 64'sh3fffffff00000001, 0);

        // Back-pressure on the first result
        run(5'd30, 6'd3, 5, -1);

        // Empty run
        run(5'd7, 6'd0, 0, -1);
        chk("count0_results", got_q.size(), 0);

        // Start during a busy run is ignored
        run(5'd30, 6'd3, 0, 1);
        chk("extra_start_results", got_q.size(), 3);

        // Full sweep of all 32 locations with random instructions
        for (int i = 0; i < 32; i++) begin
            mem[i].opc  = opcode_t'($urandom_range(0, 7));
            mem[i].op_a = operand_t'($urandom_range(0, 2000)) - 1000;
            mem[i].op_b = (i % 5 == 0) ? 0 : operand_t'($urandom_range(0, 200)) - 100;
        end
        run(5'd20, 6'd32, 0, -1);
        chk("sweep_results", got_q.size(), 32);

        // Reset while a result is stalled in the output stage
        mem[5] = '{opc: ADD, op_a: 1, op_b: 2};
        mem[6] = '{opc: SUB, op_a: 1, op_b: 2};
        for (int i = 5; i < 7; i++) begin
            exp_t x;
            bit   e;
            x.data = model(mem[i].opc, mem[i].op_a, mem[i].op_b, e);
            x.addr = 5'(i); x.opc = mem[i].opc; x.err = e;
            exp_q.push_back(x);
        end
        @(posedge clk); #1;
        res_ready = 1'b0; start = 1'b1; first_addr = 5'd5; count = 6'd2;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20 && !res_valid; c++) begin
            @(posedge clk); #1;
        end
        chk("stall_valid", longint'(res_valid), 1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("post_reset_done", longint'(done), 0);
            chk("post_reset_busy", longint'(busy), 0);
        end
        mem[3] = '{opc: ADD, op_a: 7, op_b: -2};
        run(5'd3, 6'd1, 0, -1);
        lit("after_reset_add", 0, 5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
